// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types, opcodes and address helper for the SPI slave register controller
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA,
    IGNORE
  } state_e;

  localparam logic [5:0] SPI_REG_WR_OPC = 6'h1C;
  localparam logic [5:0] SPI_REG_RD_OPC = 6'h1D;

  function automatic logic [1:0] addr_next(input logic [1:0] addr, input logic auto_inc);
    return auto_inc ? addr + 2'd1 : addr;
  endfunction

endpackage

// File: rtl/spi_slave_reg_ctrl.sv
// rtl/spi_slave_reg_ctrl.sv - command sequencer between the SPI byte path and the config register file
module spi_slave_reg_ctrl
  import spi_slave_pkg::*;
#(
  parameter logic [5:0] WR_OPC   = SPI_REG_WR_OPC,
  parameter logic [5:0] RD_OPC   = SPI_REG_RD_OPC,
  parameter bit         AUTO_INC = 1'b1
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cs_active,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] reg_wr_data,
  output logic [1:0] reg_wr_addr,
  output logic       reg_wr_valid,
  output logic [1:0] reg_rd_addr,
  input  logic [7:0] reg_rd_data,
  output logic [7:0] err_cnt,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       ld_pend_q, ld_pend_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    ld_pend_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    busy_d     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cs_active) state_d = CMD;
      end
      CMD: begin
        if (rx_valid) begin
          if (rx_data[7:2] == WR_OPC) begin
            if (cs_active) begin
              addr_d  = rx_data[1:0];
              state_d = WR_DATA;
            end
          end else if (rx_data[7:2] == RD_OPC) begin
            if (cs_active) begin
              addr_d    = rx_data[1:0];
              state_d   = RD_DATA;
              tx_load_d = 1'b1;
            end
          end else begin
            // Illegal opcodes are counted even when chip select drops with them.
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d = IGNORE;
          end
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          wr_valid_d = 1'b1;
          wr_data_d  = rx_data;
          wr_addr_d  = addr_q;
          addr_d     = addr_next(addr_q, AUTO_INC);
        end
      end
      RD_DATA: begin
        // Advance the address first so the register file settles before the load.
        if (tx_done && cs_active) begin
          addr_d    = addr_next(addr_q, AUTO_INC);
          ld_pend_d = 1'b1;
        end
        if (ld_pend_q && cs_active) tx_load_d = 1'b1;
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !cs_active) state_d = IDLE;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 2'd0;
      wr_addr_q  <= 2'd0;
      wr_data_q  <= 8'd0;
      wr_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      ld_pend_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      tx_load_q  <= tx_load_d;
      ld_pend_q  <= ld_pend_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Read data is combinational from addr, so it is presented in the load cycle itself.
  assign tx_data      = tx_load_q ? reg_rd_data : 8'h00;
  assign tx_load      = tx_load_q;
  assign reg_wr_data  = wr_data_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_rd_addr  = addr_q;
  assign err_cnt      = err_cnt_q;
  assign busy         = busy_q;

endmodule
